// File: rtl/mac_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_reg_pkg : MAC host register indices and state types for the bus master |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mac_reg_pkg;

    localparam logic [6:0] REG_CPU_RD_ADDR   = 7'd28;
    localparam logic [6:0] REG_CPU_RD_APPLY  = 7'd29;
    localparam logic [6:0] REG_CPU_RD_GRANT  = 7'd30;
    localparam logic [6:0] REG_CPU_RD_DOUT_L = 7'd31;
    localparam logic [6:0] REG_CPU_RD_DOUT_H = 7'd32;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR       = 4'd1,
        S_RD       = 4'd2,
        S_RDCAP    = 4'd3,
        S_RM_ADDR  = 4'd4,
        S_RM_APPLY = 4'd5,
        S_RM_POLL  = 4'd6,
        S_RM_LO    = 4'd7,
        S_RM_HI    = 4'd8,
        S_RM_CLR   = 4'd9,
        S_RSP      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_ACCESS  = 2'd1,
        PH_CAPTURE = 2'd2
    } phase_t;

    function automatic logic [7:0] byte_addr(input logic [6:0] idx);
        return {idx, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_bus_cycle : single CSB/WRB access engine with one-cycle read capture   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module reg_bus_cycle
    import mac_reg_pkg::*;
(
    input  logic        Clk_reg,
    input  logic        Reset,
    input  logic        start,
    input  logic        write,
    input  logic [6:0]  idx,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        CSB,
    output logic        WRB,
    output logic [7:0]  CA,
    output logic [15:0] CD_wr,
    input  logic [15:0] CD_rd
);

    phase_t r_phase;

    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            r_phase <= PH_IDLE;
            CSB     <= 1'b1;
            WRB     <= 1'b1;
            CA      <= 8'h00;
            CD_wr   <= 16'h0000;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        CSB     <= 1'b0;
                        WRB     <= ~write;
                        CA      <= byte_addr(idx);
                        if (write)
                            CD_wr <= wdata;
                        r_phase <= PH_ACCESS;
                    end
                end
                PH_ACCESS: begin
                    CSB     <= 1'b1;
                    WRB     <= 1'b1;
                    // WRB low here marks a write: nothing to capture afterwards
                    r_phase <= WRB ? PH_CAPTURE : PH_IDLE;
                end
                PH_CAPTURE: r_phase <= PH_IDLE;
                default:    r_phase <= PH_IDLE;
            endcase
        end
    end

    assign busy  = (r_phase != PH_IDLE);
    assign done  = ((r_phase == PH_ACCESS) && !WRB) || (r_phase == PH_CAPTURE);
    assign rdata = CD_rd;

endmodule
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_bus_master : MAC register bus initiator; REG_MASTER_RMON_EN adds RMON  |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module reg_bus_master
    import mac_reg_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic        Clk_reg,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_rmon,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        CSB,
    output logic        WRB,
    output logic [7:0]  CA,
    output logic [15:0] CD_wr,
    input  logic [15:0] CD_rd
);

    state_t      r_state;
    state_t      w_next;
    logic        r_write;
    logic [6:0]  r_addr;
    logic [15:0] r_wdata;
    logic [31:0] r_rsp_data;
    logic        w_accept;
    logic        w_start;
    logic        w_bus_write;
    logic [6:0]  w_bus_idx;
    logic [15:0] w_bus_wdata;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_rdata;

`ifdef REG_MASTER_RMON_EN
    logic [15:0] r_poll_cnt;
    logic        r_timeout;
    logic        w_poll_last;

    assign w_poll_last = (32'(r_poll_cnt) + 32'd1 >= POLL_LIMIT);
`endif

    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_bus_write = r_write;
        w_bus_idx   = r_addr;
        w_bus_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
`ifdef REG_MASTER_RMON_EN
                    if (cmd_rmon && !cmd_write)
                        w_next = S_RM_ADDR;
                    else
`endif
                        w_next = cmd_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                w_start = !w_busy;
                if (w_done)
                    w_next = S_RSP;
            end
            S_RD: begin
                w_start = !w_busy;
                if (w_busy)
                    w_next = S_RDCAP;
            end
            S_RDCAP: begin
                if (w_done)
                    w_next = S_RSP;
            end
`ifdef REG_MASTER_RMON_EN
            S_RM_ADDR: begin
                w_start     = !w_busy;
                w_bus_write = 1'b1;
                w_bus_idx   = REG_CPU_RD_ADDR;
                w_bus_wdata = {10'd0, r_addr[5:0]};
                if (w_done)
                    w_next = S_RM_APPLY;
            end
            S_RM_APPLY: begin
                w_start     = !w_busy;
                w_bus_write = 1'b1;
                w_bus_idx   = REG_CPU_RD_APPLY;
                w_bus_wdata = 16'h0001;
                if (w_done)
                    w_next = S_RM_POLL;
            end
            S_RM_POLL: begin
                w_start     = !w_busy;
                w_bus_write = 1'b0;
                w_bus_idx   = REG_CPU_RD_GRANT;
                // a grant on the last permitted poll still wins over the timeout
                if (w_done) begin
                    if (w_rdata[0])
                        w_next = S_RM_LO;
                    else if (w_poll_last)
                        w_next = S_RM_CLR;
                end
            end
            S_RM_LO: begin
                w_start     = !w_busy;
                w_bus_write = 1'b0;
                w_bus_idx   = REG_CPU_RD_DOUT_L;
                if (w_done)
                    w_next = S_RM_HI;
            end
            S_RM_HI: begin
                w_start     = !w_busy;
                w_bus_write = 1'b0;
                w_bus_idx   = REG_CPU_RD_DOUT_H;
                if (w_done)
                    w_next = S_RM_CLR;
            end
            S_RM_CLR: begin
                w_start     = !w_busy;
                w_bus_write = 1'b1;
                w_bus_idx   = REG_CPU_RD_APPLY;
                w_bus_wdata = 16'h0000;
                if (w_done)
                    w_next = S_RSP;
            end
`endif
            S_RSP: begin
                if (rsp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_addr     <= 7'd0;
            r_wdata    <= 16'h0000;
            r_rsp_data <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write    <= cmd_write;
                r_addr     <= cmd_addr;
                r_wdata    <= cmd_wdata;
                r_rsp_data <= 32'h0;
            end
            if (w_done) begin
                case (r_state)
                    S_RDCAP: r_rsp_data <= {16'h0000, w_rdata};
`ifdef REG_MASTER_RMON_EN
                    S_RM_LO: r_rsp_data[15:0]  <= w_rdata;
                    S_RM_HI: r_rsp_data[31:16] <= w_rdata;
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef REG_MASTER_RMON_EN
    always_ff @(posedge Clk_reg or posedge Reset) begin
        if (Reset) begin
            r_poll_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else if (w_accept) begin
            r_poll_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else if ((r_state == S_RM_POLL) && w_done && !w_rdata[0]) begin
            if (w_poll_last)
                r_timeout <= 1'b1;
            else
                r_poll_cnt <= r_poll_cnt + 16'd1;
        end
    end

    assign rsp_timeout = r_timeout;
`else
    logic w_unused;
    assign w_unused    = cmd_rmon ^ (POLL_LIMIT == 0);
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RSP);
    assign rsp_data  = r_rsp_data;

    reg_bus_cycle u_cycle (
        .Clk_reg (Clk_reg),
        .Reset   (Reset),
        .start   (w_start),
        .write   (w_bus_write),
        .idx     (w_bus_idx),
        .wdata   (w_bus_wdata),
        .busy    (w_busy),
        .done    (w_done),
        .rdata   (w_rdata),
        .CSB     (CSB),
        .WRB     (WRB),
        .CA      (CA),
        .CD_wr   (CD_wr),
        .CD_rd   (CD_rd)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_bus_master : directed bench with a 1-cycle-latency MAC slave model  |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_reg_bus_master;

    logic        Clk_reg = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_rmon = 1'b0;
    logic [6:0]  cmd_addr = 7'd0;
    logic [15:0] cmd_wdata = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        CSB;
    logic        WRB;
    logic [7:0]  CA;
    logic [15:0] CD_wr;
    logic [15:0] CD_rd = 16'h0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wrb;
        logic [7:0]  ca;
        logic [15:0] cd;
    } acc_t;

    acc_t        acc_q[$];
    int          run = 0;
    int          max_run = 0;
    logic [15:0] regs [128];
    int          poll_reads = 0;
    int          grant_at = 0;
    bit          grant_en = 1'b0;

    reg_bus_master #(.POLL_LIMIT(4)) dut (
        .Clk_reg     (Clk_reg),
        .Reset       (Reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_rmon    (cmd_rmon),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .CSB         (CSB),
        .WRB         (WRB),
        .CA          (CA),
        .CD_wr       (CD_wr),
        .CD_rd       (CD_rd)
    );

    always #5 Clk_reg = ~Clk_reg;

    // Slave: writes land on the CSB-low edge, read data appears the cycle after
    initial begin
        for (int i = 0; i < 128; i++) regs[i] <= 16'h0;
        regs[26] <= 16'h2710;
        regs[31] <= 16'hBEEF;
        regs[32] <= 16'hDEAD;
    end

    always @(posedge Clk_reg) begin
        if (!CSB && !WRB) regs[CA[7:1]] <= CD_wr;
        if (!CSB && WRB) begin
            if (CA[7:1] == 7'd30) begin
                poll_reads <= poll_reads + 1;
                CD_rd <= (grant_en && (poll_reads + 1 >= grant_at)) ? 16'h0001 : 16'h0002;
            end else begin
                CD_rd <= regs[CA[7:1]];
            end
        end else begin
            CD_rd <= 16'h5A5A;
        end
    end

    always @(negedge Clk_reg) begin
        if (!CSB) begin
            acc_q.push_back('{WRB, CA, CD_wr});
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at the first negedge after the accepting edge; inputs are then scrambled
    task automatic send_cmd(input logic w, input logic rm, input logic [6:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge Clk_reg);
        while (!cmd_ready && n < 50) begin @(negedge Clk_reg); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL cmd_ready_wait: got stuck low, want high within 50 cycles"); end
        cmd_valid = 1'b1; cmd_write = w; cmd_rmon = rm; cmd_addr = a; cmd_wdata = d;
        @(negedge Clk_reg);
        cmd_valid = 1'b0; cmd_write = ~w; cmd_rmon = 1'b0; cmd_addr = 7'h7F; cmd_wdata = 16'hFFFF;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin @(negedge Clk_reg); lat++; end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk_reg);
        checks++; if (CSB !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b want 1", CSB); end
        checks++; if (WRB !== 1'b1) begin errors++; $display("FAIL reset_wrb: got %b want 1", WRB); end
        checks++; if (CA !== 8'h00) begin errors++; $display("FAIL reset_ca: got %h want 00", CA); end
        checks++; if (CD_wr !== 16'h0) begin errors++; $display("FAIL reset_cd_wr: got %h want 0000", CD_wr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", rsp_timeout); end
        Reset = 1'b0;
        @(negedge Clk_reg);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        int base, lat;
        acc_t a;
        base = acc_q.size();
        send_cmd(1'b1, 1'b0, 7'd34, 16'h0002);
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
        checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL write_access_count: got %0d want 1", acc_q.size() - base); end
        a = (acc_q.size() > base) ? acc_q[base] : '{1'b1, 8'h00, 16'h0};
        checks++; if (a.wrb !== 1'b0) begin errors++; $display("FAIL write_wrb: got %b want 0", a.wrb); end
        checks++; if (a.ca !== 8'h44) begin errors++; $display("FAIL write_ca: got %h want 44", a.ca); end
        checks++; if (a.cd !== 16'h0002) begin errors++; $display("FAIL write_cd: got %h want 0002", a.cd); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL write_rsp_data: got %h want 0", rsp_data); end
        @(negedge Clk_reg);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_rsp_drop: got %b want 0", rsp_valid); end
        checks++; if (regs[34] !== 16'h0002) begin errors++; $display("FAIL write_slave_reg: got %h want 0002", regs[34]); end
        checks++; if (max_run != 1) begin errors++; $display("FAIL write_csb_width: got %0d want 1", max_run); end
    endtask

    task automatic test_read(input logic rm);
        int base, lat;
        acc_t a;
        base = acc_q.size();
        send_cmd(1'b0, rm, 7'd26, 16'h0);
        wait_rsp(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
        checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL read_access_count: got %0d want 1", acc_q.size() - base); end
        a = (acc_q.size() > base) ? acc_q[base] : '{1'b0, 8'h00, 16'h0};
        checks++; if (a.wrb !== 1'b1) begin errors++; $display("FAIL read_wrb: got %b want 1", a.wrb); end
        checks++; if (a.ca !== 8'h34) begin errors++; $display("FAIL read_ca: got %h want 34", a.ca); end
        checks++; if (rsp_data !== 32'h0000_2710) begin errors++; $display("FAIL read_rsp_data: got %h want 00002710", rsp_data); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL read_timeout: got %b want 0", rsp_timeout); end
        @(negedge Clk_reg);
        checks++; if (max_run != 1) begin errors++; $display("FAIL read_csb_width: got %0d want 1", max_run); end
    endtask

    task automatic test_rmon_write_plain();
        int base, lat;
        acc_t a;
        base = acc_q.size();
        send_cmd(1'b1, 1'b1, 7'd40, 16'h1234);
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL rmonwr_latency: got %0d want 2", lat); end
        checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL rmonwr_access_count: got %0d want 1", acc_q.size() - base); end
        a = (acc_q.size() > base) ? acc_q[base] : '{1'b1, 8'h00, 16'h0};
        checks++; if (a.ca !== 8'h50 || a.wrb !== 1'b0 || a.cd !== 16'h1234) begin
            errors++; $display("FAIL rmonwr_access: got wrb=%b ca=%h cd=%h want wrb=0 ca=50 cd=1234", a.wrb, a.ca, a.cd);
        end
        @(negedge Clk_reg);
        checks++; if (regs[40] !== 16'h1234) begin errors++; $display("FAIL rmonwr_slave_reg: got %h want 1234", regs[40]); end
    endtask

    task automatic test_hold();
        int base, lat;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 1'b0, 7'd34, 16'h0);
        wait_rsp(lat);
        base = acc_q.size();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'd50; cmd_wdata = 16'h7777;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk_reg);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
            checks++; if (rsp_data !== 32'h0000_0002) begin errors++; $display("FAIL hold_data[%0d]: got %h want 00000002", i, rsp_data); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_cmd_ready[%0d]: got %b want 0", i, cmd_ready); end
        end
        checks++; if (acc_q.size() != base) begin errors++; $display("FAIL hold_bus_idle: got %0d accesses want 0", acc_q.size() - base); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge Clk_reg);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", rsp_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_ready: got %b want 1", cmd_ready); end
        checks++; if (regs[50] !== 16'h0) begin errors++; $display("FAIL hold_no_write: got %h want 0000", regs[50]); end
    endtask

`ifdef REG_MASTER_RMON_EN
    task automatic test_rmon_read();
        int base, lat, p0;
        acc_t a;
        logic        e_wrb [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  e_ca  [8] = '{8'h38, 8'h3A, 8'h3C, 8'h3C, 8'h3C, 8'h3E, 8'h40, 8'h3A};
        logic [15:0] e_cd  [8] = '{16'h0005, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000};
        p0 = poll_reads;
        grant_at = poll_reads + 3;
        grant_en = 1'b1;
        base = acc_q.size();
        send_cmd(1'b0, 1'b1, 7'd5, 16'h0);
        wait_rsp(lat);
        checks++; if (lat >= 200) begin errors++; $display("FAIL rmon_rsp_seen: got no response want one"); end
        checks++; if (acc_q.size() != base + 8) begin errors++; $display("FAIL rmon_access_count: got %0d want 8", acc_q.size() - base); end
        for (int i = 0; i < 8; i++) begin
            a = (acc_q.size() > base + i) ? acc_q[base + i] : '{1'bx, 8'hxx, 16'hxxxx};
            checks++;
            if (a.wrb !== e_wrb[i] || a.ca !== e_ca[i] || (!e_wrb[i] && a.cd !== e_cd[i])) begin
                errors++; $display("FAIL rmon_access[%0d]: got wrb=%b ca=%h cd=%h want wrb=%b ca=%h cd=%h", i, a.wrb, a.ca, a.cd, e_wrb[i], e_ca[i], e_cd[i]);
            end
        end
        checks++; if (poll_reads - p0 != 3) begin errors++; $display("FAIL rmon_polls: got %0d want 3", poll_reads - p0); end
        checks++; if (rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmon_rsp_data: got %h want deadbeef", rsp_data); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rmon_timeout: got %b want 0", rsp_timeout); end
        @(negedge Clk_reg);
        checks++; if (regs[29] !== 16'h0) begin errors++; $display("FAIL rmon_apply_clear: got %h want 0000", regs[29]); end
        checks++; if (max_run != 1) begin errors++; $display("FAIL rmon_csb_width: got %0d want 1", max_run); end
    endtask

    task automatic test_rmon_timeout();
        int base, lat, p0;
        acc_t a;
        logic        e_wrb [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  e_ca  [7] = '{8'h38, 8'h3A, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3A};
        logic [15:0] e_cd  [7] = '{16'h0009, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000};
        p0 = poll_reads;
        grant_en = 1'b0;
        base = acc_q.size();
        send_cmd(1'b0, 1'b1, 7'd9, 16'h0);
        wait_rsp(lat);
        checks++; if (lat >= 200) begin errors++; $display("FAIL tmo_rsp_seen: got no response want one"); end
        checks++; if (acc_q.size() != base + 7) begin errors++; $display("FAIL tmo_access_count: got %0d want 7", acc_q.size() - base); end
        for (int i = 0; i < 7; i++) begin
            a = (acc_q.size() > base + i) ? acc_q[base + i] : '{1'bx, 8'hxx, 16'hxxxx};
            checks++;
            if (a.wrb !== e_wrb[i] || a.ca !== e_ca[i] || (!e_wrb[i] && a.cd !== e_cd[i])) begin
                errors++; $display("FAIL tmo_access[%0d]: got wrb=%b ca=%h cd=%h want wrb=%b ca=%h cd=%h", i, a.wrb, a.ca, a.cd, e_wrb[i], e_ca[i], e_cd[i]);
            end
        end
        checks++; if (poll_reads - p0 != 4) begin errors++; $display("FAIL tmo_polls: got %0d want 4", poll_reads - p0); end
        checks++; if (rsp_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", rsp_timeout); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL tmo_rsp_data: got %h want 0", rsp_data); end
        @(negedge Clk_reg);
    endtask
`endif

    task automatic test_reset_mid();
        int n, base, lat;
        acc_t a;
        logic [7:0] target;
`ifdef REG_MASTER_RMON_EN
        grant_en = 1'b0;
        target = 8'h3C;
        send_cmd(1'b0, 1'b1, 7'd7, 16'h0);
`else
        target = 8'h34;
        send_cmd(1'b0, 1'b0, 7'd26, 16'h0);
`endif
        n = 0;
        while (!(CSB === 1'b0 && CA === target) && n < 100) begin @(negedge Clk_reg); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL midrst_reach: got no access to %h want one", target); end
        Reset = 1'b1;
        #1;
        checks++; if (CSB !== 1'b1) begin errors++; $display("FAIL midrst_csb: got %b want 1", CSB); end
        checks++; if (WRB !== 1'b1) begin errors++; $display("FAIL midrst_wrb: got %b want 1", WRB); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
        @(negedge Clk_reg);
        Reset = 1'b0;
`ifdef REG_MASTER_RMON_EN
        checks++; if (regs[29] !== 16'h0001) begin errors++; $display("FAIL midrst_apply_kept: got %h want 0001", regs[29]); end
`endif
        base = acc_q.size();
        send_cmd(1'b1, 1'b0, 7'd35, 16'hABCD);
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL midrst_next_latency: got %0d want 2", lat); end
        checks++; if (acc_q.size() != base + 1) begin errors++; $display("FAIL midrst_next_count: got %0d want 1", acc_q.size() - base); end
        a = (acc_q.size() > base) ? acc_q[base] : '{1'b1, 8'h00, 16'h0};
        checks++; if (a.wrb !== 1'b0 || a.ca !== 8'h46 || a.cd !== 16'hABCD) begin
            errors++; $display("FAIL midrst_next_access: got wrb=%b ca=%h cd=%h want wrb=0 ca=46 cd=abcd", a.wrb, a.ca, a.cd);
        end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL midrst_next_timeout: got %b want 0", rsp_timeout); end
        @(negedge Clk_reg);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(1'b0);
        test_rmon_write_plain();
        test_hold();
`ifdef REG_MASTER_RMON_EN
        test_rmon_read();
        test_rmon_timeout();
`else
        test_read(1'b1);
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
